// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART receive path.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    localparam int unsigned UART_DATA_BITS          = 8;
    localparam int unsigned UART_OVERSAMPLE_DEFAULT = 16;

endpackage

// File: rtl/rx_bit_sampler.sv
// Line synchroniser, oversample tick counter and bit sampler for the UART receiver.
// Optional 2-of-3 majority vote per sample point under UART_RX_MAJORITY_VOTE_EN.
`timescale 1ns/1ps
module rx_bit_sampler import uart_pkg::*; #(
    parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx_serial_in,
    input  rx_state_t state,
    output logic      rxs,
    output logic      sample_strobe,
    output logic      sample_bit
);

    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [TickW-1:0]       tick_q, tick_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            tick_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_serial_in};
            tick_q <= tick_d;
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    always_comb begin
        sample_strobe = 1'b0;
        case (state)
            RX_START:         sample_strobe = (tick_q == TickMid);
            RX_DATA, RX_STOP: sample_strobe = (tick_q == TickLast);
            default:          sample_strobe = 1'b0;
        endcase
    end

    // Held at zero in IDLE, so IDLE->START starts from a cleared count.
    always_comb begin
        tick_d = tick_q + 1'b1;
        if (state == RX_IDLE || (state == RX_START && sample_strobe)) begin
            tick_d = '0;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic rxs_prev_q;
    logic rxs_next;

    // The t+1 value is already in the penultimate sync stage, so voting adds no latency.
    assign rxs_next = sync_q[SYNC_STAGES-2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxs_prev_q <= 1'b1;
        end else begin
            rxs_prev_q <= rxs;
        end
    end

    assign sample_bit = (rxs_prev_q & rxs) | (rxs_prev_q & rxs_next) | (rxs & rxs_next);
`else
    assign sample_bit = rxs;
`endif

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a one-entry ready/valid output buffer, framing-error and overrun pulses.
// Build option: UART_RX_MAJORITY_VOTE_EN enables 2-of-3 majority sampling in rx_bit_sampler.
`timescale 1ns/1ps
module uart_receiver import uart_pkg::*; #(
    parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_serial_in,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam int unsigned BitCntW = $clog2(UART_DATA_BITS);
    localparam logic [BitCntW-1:0] BitCntLast = BitCntW'(UART_DATA_BITS - 1);

    rx_state_t                 state_q, state_d;
    logic [BitCntW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      stop_ok_q, stop_ok_d;
    logic                      stop_bad_q, stop_bad_d;
    logic [7:0]                data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      frame_err_q, overrun_q, overrun_d;
    logic                      rxs, sample_strobe, sample_bit;

    rx_bit_sampler #(
        .OVERSAMPLE  (OVERSAMPLE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_serial_in  (rx_serial_in),
        .state         (state_q),
        .rxs           (rxs),
        .sample_strobe (sample_strobe),
        .sample_bit    (sample_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RX_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            stop_ok_q  <= 1'b0;
            stop_bad_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            stop_ok_q  <= stop_ok_d;
            stop_bad_q <= stop_bad_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RX_IDLE:  if (!rxs) state_d = RX_START;
            RX_START: if (sample_strobe) state_d = sample_bit ? RX_IDLE : RX_DATA;
            RX_DATA:  if (sample_strobe && bit_cnt_q == BitCntLast) state_d = RX_STOP;
            RX_STOP:  if (sample_strobe) state_d = RX_IDLE;
            default:  state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        stop_ok_d  = 1'b0;
        stop_bad_d = 1'b0;
        if (state_q == RX_DATA && sample_strobe) begin
            shift_d   = {sample_bit, shift_q[UART_DATA_BITS-1:1]};
            bit_cnt_d = (bit_cnt_q == BitCntLast) ? '0 : bit_cnt_q + 1'b1;
        end
        if (state_q == RX_STOP && sample_strobe) begin
            stop_ok_d  = sample_bit;
            stop_bad_d = !sample_bit;
        end
    end

    // A consume and a new byte in the same cycle keeps valid high with the new byte.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (valid_q && rx_data_ready) begin
            valid_d = 1'b0;
        end
        if (stop_ok_q) begin
            if (!valid_q || rx_data_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= stop_bad_q;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data       = data_q;
    assign rx_data_valid = valid_q;
    assign rx_frame_err  = frame_err_q;
    assign rx_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at default parameters (16 clk/bit, 2 sync stages).
`timescale 1ns/1ps
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx_serial_in = 1'b1;
    logic       rx_data_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_frame_err;
    logic       rx_overrun;

    int         n_tests = 0;
    int         n_fail = 0;
    int         ovr_cnt = 0;
    int         ferr_cnt = 0;
    int         push_cnt = 0;
    int         pop_cnt = 0;
    int         lat_cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] glitch_exp;

    always #5 clk = ~clk;

    uart_receiver u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_serial_in  (rx_serial_in),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready),
        .rx_frame_err  (rx_frame_err),
        .rx_overrun    (rx_overrun)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] b);
        exp_q.push_back(b);
        push_cnt++;
    endtask

    // One frame: start, 8 data LSB first, stop; 16 negedge drives per bit, then one idle cycle.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int glitch_bit);
        logic [9:0] bits;
        bits = {stop_bit, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                if (glitch_bit >= 0 && b == glitch_bit + 1 && c == 8) rx_serial_in = ~bits[b];
                else rx_serial_in = bits[b];
            end
        end
        @(negedge clk);
        rx_serial_in = 1'b1;
    endtask

    // Monitor: handshakes pop the scoreboard; status pulses are counted.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (rx_overrun) ovr_cnt++;
            if (rx_frame_err) ferr_cnt++;
            if (rx_data_valid && rx_data_ready) begin
                check_eq("sb_depth", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    check_eq("sb_data", rx_data, exp_q.pop_front());
                    pop_cnt++;
                end
            end
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_valid", rx_data_valid, 0);
        check_eq("rst_data", rx_data, 0);
        check_eq("rst_ferr", rx_frame_err, 0);
        check_eq("rst_ovr", rx_overrun, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 0xA5: latency from start edge, then held until accepted
        push_exp(8'hA5);
        fork
            send_frame(8'hA5, 1'b1, -1);
            begin
                @(negedge clk);
                @(posedge clk);
                lat_cyc = 0;
                while (lat_cyc < 300) begin
                    @(posedge clk);
                    lat_cyc++;
                    #1;
                    if (rx_data_valid) break;
                end
                check_eq("latency", lat_cyc, 155);
            end
        join
        check_eq("a5_valid", rx_data_valid, 1);
        check_eq("a5_data", rx_data, 8'hA5);
        repeat (4) @(negedge clk);
        check_eq("a5_held", rx_data_valid, 1);
        @(negedge clk);
        rx_data_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("a5_cleared", rx_data_valid, 0);

        // Short low pulse on idle line is rejected silently
        @(negedge clk);
        rx_serial_in = 1'b0;
        repeat (4) @(negedge clk);
        rx_serial_in = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("glitch_valid", rx_data_valid, 0);
        check_eq("glitch_ferr", ferr_cnt, 0);

        // Stop bit low: frame error, byte dropped
        send_frame(8'h3C, 1'b0, -1);
        repeat (10) @(negedge clk);
        check_eq("ferr_cnt", ferr_cnt, 1);
        check_eq("ferr_valid", rx_data_valid, 0);

        // Back-to-back with ready low: second byte overruns
        rx_data_ready = 1'b0;
        push_exp(8'h3C);
        send_frame(8'h3C, 1'b1, -1);
        send_frame(8'hC3, 1'b1, -1);
        repeat (4) @(negedge clk);
        check_eq("ovr_cnt", ovr_cnt, 1);
        check_eq("ovr_valid", rx_data_valid, 1);
        check_eq("ovr_data", rx_data, 8'h3C);
        @(negedge clk);
        rx_data_ready = 1'b1;
        @(negedge clk);
        rx_data_ready = 1'b0;
        check_eq("ovr_drained", rx_data_valid, 0);

        // Back-to-back with ready only in the second completion cycle
        push_exp(8'h3C);
        send_frame(8'h3C, 1'b1, -1);
        push_exp(8'hC3);
        fork
            send_frame(8'hC3, 1'b1, -1);
            begin
                repeat (156) @(negedge clk);
                rx_data_ready = 1'b1;
                @(negedge clk);
                rx_data_ready = 1'b0;
            end
        join
        repeat (2) @(negedge clk);
        check_eq("swap_valid", rx_data_valid, 1);
        check_eq("swap_data", rx_data, 8'hC3);
        check_eq("swap_no_ovr", ovr_cnt, 1);
        rx_data_ready = 1'b1;
        @(negedge clk);

        // Asynchronous reset mid-DATA with a byte pending
        rx_data_ready = 1'b0;
        push_exp(8'h55);
        send_frame(8'h55, 1'b1, -1);
        check_eq("pre_rst_valid", rx_data_valid, 1);
        rx_serial_in = 1'b0;
        repeat (16) @(negedge clk);
        rx_serial_in = 1'b1;
        repeat (40) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", rx_data_valid, 0);
        check_eq("mid_rst_data", rx_data, 0);
        push_cnt = push_cnt - exp_q.size();
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        rx_data_ready = 1'b1;
        push_exp(8'h81);
        send_frame(8'h81, 1'b1, -1);
        repeat (5) @(negedge clk);

        // One-cycle high glitch at the mid-bit sample point of data bit 3
`ifdef UART_RX_MAJORITY_VOTE_EN
        glitch_exp = 8'h00;
`else
        glitch_exp = 8'h08;
`endif
        push_exp(glitch_exp);
        send_frame(8'h00, 1'b1, 3);
        repeat (5) @(negedge clk);

        check_eq("sb_drained", exp_q.size(), 0);
        check_eq("sb_count", pop_cnt, push_cnt);
        check_eq("final_ovr", ovr_cnt, 1);
        check_eq("final_ferr", ferr_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
